multicycle_datapath: RTL and testbench

//  Parametrised multicycle MIPS-subset processor core: one FSM-sequenced datapath, shared ALU, one memory port.

---
 rtl/multicycle_datapath.sv | 212 +++++++++++++++++++++
 tb/tb_multicycle_datapath.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_datapath.sv
// Multicycle MIPS-subset core: FSM-sequenced datapath with one shared ALU and a single
// handshaked memory port used for both instruction fetch and data access.
module multicycle_datapath #(
   parameter int unsigned ADDR_W   = 32,
   parameter logic [31:0] RESET_PC = 32'h0,
   parameter int unsigned NREGS    = 32
) (
   input  logic              clock,
   input  logic              reset,
   output logic              memReq,
   output logic              memWE,
   output logic [ADDR_W-1:0] memAddr,
   output logic [31:0]       memWData,
   input  logic [31:0]       memRData,
   input  logic              memReady,
   input  logic [4:0]        dbgAddr,
   output logic [31:0]       dbgData,
   output logic [ADDR_W-1:0] pcQ,
   output logic [31:0]       instr,
   output logic [3:0]        state,
   output logic              regWriteEnable,
   output logic              halted,
   output logic              illegal
);
   localparam int unsigned RW = $clog2(NREGS);

   localparam logic [3:0] StFetch  = 4'd0,  StDecode = 4'd1, StExec  = 4'd2, StMemAddr = 4'd3,
                          StMemRd  = 4'd4,  StMemWr  = 4'd5, StWbAlu = 4'd6, StWbMem   = 4'd7,
                          StBranch = 4'd8,  StJump   = 4'd9, StHalt  = 4'd15;

   localparam logic [5:0] OpRtype = 6'h00, OpJ = 6'h02, OpBeq = 6'h04, OpAddi = 6'h08,
                          OpLw = 6'h23, OpSw = 6'h2B, OpHalt = 6'h3F;

   logic [3:0]        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [31:0]       ir_q, ir_d, a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
   logic              illegal_q, illegal_d;
   logic [31:0]       regs [NREGS];

   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, rf_dest;
   logic [31:0] sign_imm, rs_val, rt_val, alu_r, ea, br_target, pc32, jump_target, rf_wdata;
   logic [3:0]  dec_next;
   logic        dec_illegal, funct_ok, rf_we;

   function automatic logic reg_ok(input logic [4:0] idx);
      return 32'(idx) < NREGS;
   endfunction

   assign opcode      = ir_q[31:26];
   assign rs          = ir_q[25:21];
   assign rt          = ir_q[20:16];
   assign rd          = ir_q[15:11];
   assign funct       = ir_q[5:0];
   assign sign_imm    = {{16{ir_q[15]}}, ir_q[15:0]};
   assign rs_val      = reg_ok(rs) ? regs[rs[RW-1:0]] : '0;
   assign rt_val      = reg_ok(rt) ? regs[rt[RW-1:0]] : '0;
   assign ea          = a_q + sign_imm;
   assign pc32        = 32'(pc_q);
   assign br_target   = pc32 + {sign_imm[29:0], 2'b00};
   assign jump_target = {pc32[31:28], ir_q[25:0], 2'b00};
   assign funct_ok    = funct == 6'h20 || funct == 6'h22 || funct == 6'h24 ||
                        funct == 6'h25 || funct == 6'h2A;

   always_comb begin
      dec_next    = StHalt;
      dec_illegal = 1'b1;
      case (opcode)
         OpRtype: begin
            // IR==0 is a NOP, even though funct 0 is not a supported R-type op
            if (ir_q == '0 || (funct_ok && reg_ok(rs) && reg_ok(rt) && reg_ok(rd))) begin
               dec_next    = StExec;
               dec_illegal = 1'b0;
            end
         end
         OpAddi, OpLw, OpSw, OpBeq: begin
            if (reg_ok(rs) && reg_ok(rt)) begin
               dec_illegal = 1'b0;
               if (opcode == OpAddi)     dec_next = StExec;
               else if (opcode == OpBeq) dec_next = StBranch;
               else                      dec_next = StMemAddr;
            end
         end
         OpJ: begin
            dec_next    = StJump;
            dec_illegal = 1'b0;
         end
         OpHalt:  dec_illegal = 1'b0;
         default: ;
      endcase
   end

   always_comb begin
      case (funct)
         6'h20:   alu_r = a_q + b_q;
         6'h22:   alu_r = a_q - b_q;
         6'h24:   alu_r = a_q & b_q;
         6'h25:   alu_r = a_q | b_q;
         6'h2A:   alu_r = {31'b0, $signed(a_q) < $signed(b_q)};
         default: alu_r = '0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      a_d       = a_q;
      b_d       = b_q;
      alu_d     = alu_q;
      mdr_d     = mdr_q;
      illegal_d = illegal_q;
      case (state_q)
         StFetch: begin
            if (memReady) begin
               ir_d    = memRData;
               pc_d    = pc_q + ADDR_W'(4);
               state_d = StDecode;
            end
         end
         StDecode: begin
            a_d       = rs_val;
            b_d       = rt_val;
            alu_d     = br_target;
            state_d   = dec_next;
            illegal_d = dec_illegal;
         end
         StExec: begin
            alu_d   = (opcode == OpAddi) ? a_q + sign_imm : alu_r;
            state_d = StWbAlu;
         end
         StMemAddr: begin
            alu_d = ea;
            if (ea[1:0] != 2'b00) begin
               state_d   = StHalt;
               illegal_d = 1'b1;
            end else begin
               state_d = (opcode == OpLw) ? StMemRd : StMemWr;
            end
         end
         StMemRd: begin
            if (memReady) begin
               mdr_d   = memRData;
               state_d = StWbMem;
            end
         end
         StMemWr:  if (memReady) state_d = StFetch;
         StWbAlu, StWbMem: state_d = StFetch;
         StBranch: begin
            if (a_q == b_q) pc_d = alu_q[ADDR_W-1:0];
            state_d = StFetch;
         end
         StJump: begin
            pc_d    = jump_target[ADDR_W-1:0];
            state_d = StFetch;
         end
         StHalt:  ;
         default: begin
            state_d   = StHalt;
            illegal_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= StFetch;
         pc_q      <= RESET_PC[ADDR_W-1:0];
         ir_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         alu_q     <= '0;
         mdr_q     <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         a_q       <= a_d;
         b_q       <= b_d;
         alu_q     <= alu_d;
         mdr_q     <= mdr_d;
         illegal_q <= illegal_d;
      end
   end

   assign rf_we    = (state_q == StWbAlu && ir_q != '0) || state_q == StWbMem;
   assign rf_dest  = (state_q == StWbAlu && opcode == OpRtype) ? rd : rt;
   assign rf_wdata = (state_q == StWbMem) ? mdr_q : alu_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
      end else if (rf_we && rf_dest != 5'd0) begin
         regs[rf_dest[RW-1:0]] <= rf_wdata;
      end
   end

   assign memReq         = !reset && (state_q == StFetch || state_q == StMemRd ||
                                      state_q == StMemWr);
   assign memWE          = !reset && state_q == StMemWr;
   assign memAddr        = (state_q == StFetch) ? pc_q : alu_q[ADDR_W-1:0];
   assign memWData       = b_q;
   assign regWriteEnable = !reset && rf_we;
   assign dbgData        = reg_ok(dbgAddr) ? regs[dbgAddr[RW-1:0]] : '0;
   assign pcQ            = pc_q;
   assign instr          = ir_q;
   assign state          = state_q;
   assign halted         = state_q == StHalt;
   assign illegal        = illegal_q;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath: small programs in a word memory with a
// programmable wait-state responder, checked through the debug register port.
module tb_multicycle_datapath;
   logic        clock, reset, memReq, memWE, memReady, regWriteEnable, halted, illegal;
   logic [31:0] memAddr, memWData, memRData, dbgData, pcQ, instr;
   logic [4:0]  dbgAddr;
   logic [3:0]  state;

   logic        reset16, memReq16, memWE16, rwe16, halted16, illegal16;
   logic [31:0] memAddr16, memWData16, memRData16, dbgData16, pcQ16, instr16;
   logic [4:0]  dbgAddr16;
   logic [3:0]  state16;

   logic [31:0] mem [256];
   logic [31:0] wmem [256];
   logic        wvalid [256];
   logic [7:0]  widx, widx16;
   int          wcnt, wait_cycles;
   int          passed, total, fails, cyc, wr_pulses, sw_cycles, data_req;

   localparam logic [31:0] HaltI = 32'hFC00_0000;

   multicycle_datapath u_dut (
      .clock(clock), .reset(reset), .memReq(memReq), .memWE(memWE), .memAddr(memAddr),
      .memWData(memWData), .memRData(memRData), .memReady(memReady), .dbgAddr(dbgAddr),
      .dbgData(dbgData), .pcQ(pcQ), .instr(instr), .state(state),
      .regWriteEnable(regWriteEnable), .halted(halted), .illegal(illegal)
   );

   multicycle_datapath #(.NREGS(16)) u_dut16 (
      .clock(clock), .reset(reset16), .memReq(memReq16), .memWE(memWE16),
      .memAddr(memAddr16), .memWData(memWData16), .memRData(memRData16),
      .memReady(memReq16), .dbgAddr(dbgAddr16), .dbgData(dbgData16), .pcQ(pcQ16),
      .instr(instr16), .state(state16), .regWriteEnable(rwe16), .halted(halted16),
      .illegal(illegal16)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Memory responder: each access sees wait_cycles cycles of memReady=0 first
   assign widx       = memAddr[9:2];
   assign widx16     = memAddr16[9:2];
   assign memRData   = wvalid[widx] ? wmem[widx] : mem[widx];
   assign memRData16 = mem[widx16];
   assign memReady   = memReq && (wcnt >= wait_cycles);

   always @(posedge clock) begin
      if (!memReq || memReady) wcnt <= 0;
      else wcnt <= wcnt + 1;
   end

   always @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) wvalid[i] <= 1'b0;
      end else if (memReq && memWE && memReady) begin
         wvalid[widx] <= 1'b1;
         wmem[widx]   <= memWData;
      end
   end

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'h00, fn};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_reg(input string tag, input logic [4:0] idx, input logic [31:0] exp);
      dbgAddr = idx;
      #1;
      check(tag, dbgData, exp);
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic wait_state(input string tag, input logic [3:0] s);
      int n = 0;
      while (state !== s && n < 300) begin
         @(negedge clock);
         n++;
      end
      check(tag, 32'(state), 32'(s));
   endtask

   task automatic wait_halt(input string tag);
      int n = 0;
      while (halted !== 1'b1 && n < 500) begin
         @(negedge clock);
         n++;
      end
      check(tag, 32'(halted), 32'd1);
   endtask

   initial begin
      passed = 0; total = 0; fails = 0; wait_cycles = 0;
      dbgAddr = 5'd0; dbgAddr16 = 5'd0; reset16 = 1'b1;
      clear_mem();

      // Reset state and program 1: addi/addi/add/halt with no wait states
      mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
      mem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
      mem[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
      mem[3] = HaltI;
      reset = 1'b1;
      #1;
      check("rst_state", 32'(state), 32'd0);
      check("rst_pc", pcQ, 32'h0);
      check("rst_memreq", 32'(memReq), 32'd0);
      check("rst_rwe", 32'(regWriteEnable), 32'd0);
      check("rst_ir", instr, 32'h0);
      check("rst_halted", 32'(halted), 32'd0);
      do_reset();
      for (int i = 0; i < 13; i++) @(negedge clock);
      check("p1_decode_halt_at13", 32'(state), 32'd1);
      check("p1_ir_halt", instr, HaltI);
      @(negedge clock);
      check("p1_halted", 32'(halted), 32'd1);
      check("p1_illegal", 32'(illegal), 32'd0);
      check("p1_state15", 32'(state), 32'd15);
      check_reg("p1_r1", 5'd1, 32'd5);
      check_reg("p1_r2", 5'd2, 32'hFFFF_FFFD);
      check_reg("p1_r3", 5'd3, 32'd2);

      // Program 2: store/load with two wait cycles per access
      clear_mem();
      wait_cycles = 2;
      mem[0]  = {6'h02, 26'h20};
      mem[16] = 32'hDEAD_BEEF;
      mem[32] = enc_i(6'h23, 5'd0, 5'd1, 16'h0040);
      mem[33] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0008);
      mem[34] = enc_i(6'h23, 5'd0, 5'd4, 16'h0008);
      mem[35] = HaltI;
      do_reset();
      cyc = 0; sw_cycles = 0;
      while (!halted && cyc < 400) begin
         @(negedge clock);
         cyc++;
         if (memReq && memWE) begin
            sw_cycles++;
            check("p2_sw_addr", memAddr, 32'h8);
            check("p2_sw_wdata", memWData, 32'hDEAD_BEEF);
         end
      end
      check("p2_halted", 32'(halted), 32'd1);
      check("p2_sw_req_cycles", sw_cycles, 32'd3);
      check("p2_mem_written", wvalid[2] ? wmem[2] : 32'h0, 32'hDEAD_BEEF);
      check_reg("p2_r1", 5'd1, 32'hDEAD_BEEF);
      check_reg("p2_r4", 5'd4, 32'hDEAD_BEEF);

      // Program 3: ALU ops, signed slt, wrap, write to $0, NOP
      clear_mem();
      wait_cycles = 0;
      mem[0]  = enc_i(6'h08, 5'd0, 5'd6, 16'hFFFF);
      mem[1]  = enc_i(6'h08, 5'd0, 5'd7, 16'd1);
      mem[2]  = enc_r(5'd6, 5'd7, 5'd5, 6'h2A);
      mem[3]  = enc_r(5'd0, 5'd7, 5'd9, 6'h22);
      mem[4]  = enc_r(5'd6, 5'd7, 5'd10, 6'h24);
      mem[5]  = enc_i(6'h08, 5'd0, 5'd12, 16'h00F0);
      mem[6]  = enc_r(5'd12, 5'd7, 5'd11, 6'h25);
      mem[7]  = enc_r(5'd6, 5'd7, 5'd13, 6'h20);
      mem[8]  = enc_r(5'd7, 5'd6, 5'd14, 6'h2A);
      mem[9]  = enc_i(6'h08, 5'd0, 5'd0, 16'd7);
      mem[10] = 32'h0;
      mem[11] = HaltI;
      do_reset();
      cyc = 0; wr_pulses = 0;
      while (!halted && cyc < 400) begin
         @(negedge clock);
         cyc++;
         if (regWriteEnable) wr_pulses++;
      end
      check("p3_halted", 32'(halted), 32'd1);
      check("p3_wr_pulses", wr_pulses, 32'd10);
      check_reg("p3_slt_signed", 5'd5, 32'd1);
      check_reg("p3_sub_wrap", 5'd9, 32'hFFFF_FFFF);
      check_reg("p3_and", 5'd10, 32'd1);
      check_reg("p3_or", 5'd11, 32'h0000_00F1);
      check_reg("p3_add_wrap", 5'd13, 32'h0);
      check_reg("p3_slt_false", 5'd14, 32'd0);
      check_reg("p3_r0_zero", 5'd0, 32'd0);

      // Program 4a: beq taken at 0x10 with imm=-4
      clear_mem();
      mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
      mem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd2);
      mem[4] = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFC);
      do_reset();
      wait_state("p4a_reach_branch", 4'd8);
      check("p4a_pc_in_branch", pcQ, 32'h14);
      @(negedge clock);
      check("p4a_taken_fetch", memAddr, 32'h4);

      // Program 4b: beq not taken, then j 0x40
      mem[4]  = enc_i(6'h04, 5'd1, 5'd0, 16'hFFFC);
      mem[5]  = {6'h02, 26'h40};
      mem[64] = HaltI;
      do_reset();
      wait_state("p4b_reach_branch", 4'd8);
      @(negedge clock);
      check("p4b_not_taken_fetch", memAddr, 32'h14);
      wait_state("p4b_reach_jump", 4'd9);
      @(negedge clock);
      check("p4b_jump_fetch", memAddr, 32'h100);
      wait_halt("p4b_halted");
      check("p4b_illegal", 32'(illegal), 32'd0);

      // Program 5: misaligned lw, bad opcode, bad funct
      clear_mem();
      mem[0] = enc_i(6'h23, 5'd0, 5'd1, 16'd2);
      do_reset();
      cyc = 0; data_req = 0;
      while (!halted && cyc < 100) begin
         @(negedge clock);
         cyc++;
         if (memReq && state != 4'd0) data_req++;
      end
      check("p5_misalign_halted", 32'(halted), 32'd1);
      check("p5_misalign_illegal", 32'(illegal), 32'd1);
      check("p5_no_data_req", data_req, 32'd0);
      mem[0] = {6'h3E, 26'h0};
      do_reset();
      wait_halt("p5_op3e_halted");
      check("p5_op3e_illegal", 32'(illegal), 32'd1);
      mem[0] = enc_r(5'd1, 5'd2, 5'd3, 6'h21);
      do_reset();
      wait_halt("p5_funct_halted");
      check("p5_funct_illegal", 32'(illegal), 32'd1);

      // NREGS=16 core: rd=20 is out of range
      reset = 1'b1;
      mem[0] = enc_r(5'd1, 5'd2, 5'd20, 6'h20);
      @(negedge clock);
      reset16 = 1'b0;
      cyc = 0;
      while (!halted16 && cyc < 50) begin
         @(negedge clock);
         cyc++;
      end
      check("n16_halted", 32'(halted16), 32'd1);
      check("n16_illegal", 32'(illegal16), 32'd1);
      dbgAddr16 = 5'd20;
      #1;
      check("n16_dbg_oob_zero", dbgData16, 32'h0);
      reset16 = 1'b1;
      @(negedge clock);

      // Program 6: reset while MEMWR is waiting on memReady
      clear_mem();
      wait_cycles = 20;
      mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
      mem[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0020);
      do_reset();
      wait_state("p6_reach_memwr", 4'd5);
      @(negedge clock);
      @(negedge clock);
      check("p6_pending_req", 32'(memReq), 32'd1);
      check_reg("p6_r1_before", 5'd1, 32'd5);
      #2;
      reset = 1'b1;
      #1;
      check("p6_req_dropped", 32'(memReq), 32'd0);
      check("p6_we_dropped", 32'(memWE), 32'd0);
      check("p6_state_fetch", 32'(state), 32'd0);
      check("p6_pc_reset", pcQ, 32'h0);
      check("p6_no_write", 32'(wvalid[8]), 32'd0);
      check_reg("p6_r1_cleared", 5'd1, 32'd0);
      @(negedge clock);
      reset = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
